// File: rtl/thor2022_rf_scoreboard.sv
// Thor2022 register-file scoreboard and write-port arbiter (ALU vs. held memory writeback).
// Optional: define THOR2022_SB_WBBYPASS_EN to treat the register being written this cycle as free.
module thor2022_rf_scoreboard #(
  parameter int STARVE_LIM = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        iss_v_i,
  input  logic [5:0]  iss_rt_i,
  input  logic [5:0]  iss_ra_i,
  input  logic [5:0]  iss_rb_i,
  input  logic [5:0]  iss_rc_i,
  output logic        iss_rdy_o,
  input  logic        alu_wb_v_i,
  input  logic [5:0]  alu_wb_rt_i,
  input  logic [63:0] alu_wb_dat_i,
  output logic        alu_wb_rdy_o,
  input  logic        mem_wb_v_i,
  input  logic [5:0]  mem_wb_rt_i,
  input  logic [63:0] mem_wb_dat_i,
  output logic        mem_wb_rdy_o,
  output logic        rf_we_o,
  output logic [5:0]  rf_wa_o,
  output logic [63:0] rf_wd_o,
  output logic [63:0] busy_o
);

  localparam int CW = $clog2(STARVE_LIM + 2);

  logic [63:0]   r_busy;
  logic          r_hold_v;
  logic [5:0]    r_hold_rt;
  logic [63:0]   r_hold_dat;
  logic [CW-1:0] r_starve_cnt;
  logic          r_rf_we;
  logic [5:0]    r_rf_wa;
  logic [63:0]   r_rf_wd;

  logic          w_starved;
  logic          w_hold_win;
  logic          w_alu_win;
  logic          w_mem_acc;
  logic          w_issue;
  logic          w_wr_v;
  logic          w_wr_en;
  logic [5:0]    w_wr_rt;
  logic [63:0]   w_wr_dat;
  logic [63:0]   w_busy_vis;
  logic [63:0]   w_busy_next;

  // Arbitration: ALU has priority unless the held load has lost STARVE_LIM times in a row.
  assign w_starved  = r_hold_v && (r_starve_cnt == CW'(STARVE_LIM));
  assign w_hold_win = r_hold_v && (!alu_wb_v_i || w_starved);
  assign w_alu_win  = alu_wb_v_i && !w_starved;

  assign alu_wb_rdy_o = !w_starved;
  // A draining entry frees the buffer in time for a new load on the same edge.
  assign mem_wb_rdy_o = !r_hold_v || w_hold_win;
  assign w_mem_acc    = mem_wb_v_i && mem_wb_rdy_o;

  assign w_wr_v   = w_hold_win || w_alu_win;
  assign w_wr_rt  = w_hold_win ? r_hold_rt  : alu_wb_rt_i;
  assign w_wr_dat = w_hold_win ? r_hold_dat : alu_wb_dat_i;
  assign w_wr_en  = w_wr_v && (w_wr_rt != 6'd0);

`ifdef THOR2022_SB_WBBYPASS_EN
  assign w_busy_vis = r_rf_we ? (r_busy & ~(64'd1 << r_rf_wa)) : r_busy;
`else
  assign w_busy_vis = r_busy;
`endif

  assign iss_rdy_o = !(w_busy_vis[iss_ra_i] | w_busy_vis[iss_rb_i] |
                       w_busy_vis[iss_rc_i] | w_busy_vis[iss_rt_i]);
  assign w_issue   = iss_v_i && iss_rdy_o;

  // Priority low to high: write-edge clear, issue set, flush.
  always_comb begin
    w_busy_next = r_busy;
    if (r_rf_we) begin
      w_busy_next[r_rf_wa] = 1'b0;
    end
    if (w_issue && (iss_rt_i != 6'd0)) begin
      w_busy_next[iss_rt_i] = 1'b1;
    end
    if (flush_i) begin
      w_busy_next = '0;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_hold_v     <= 1'b0;
      r_hold_rt    <= '0;
      r_hold_dat   <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_mem_acc) begin
        r_hold_v   <= 1'b1;
        r_hold_rt  <= mem_wb_rt_i;
        r_hold_dat <= mem_wb_dat_i;
      end else if (w_hold_win) begin
        r_hold_v   <= 1'b0;
      end
      if (!r_hold_v || w_hold_win) begin
        r_starve_cnt <= '0;
      end else begin
        r_starve_cnt <= r_starve_cnt + CW'(1);
      end
    end
  end

  // Writes to register 0 are consumed by arbitration but never reach the port.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rf_we <= 1'b0;
      r_rf_wa <= '0;
      r_rf_wd <= '0;
    end else begin
      r_rf_we <= w_wr_en;
      if (w_wr_en) begin
        r_rf_wa <= w_wr_rt;
        r_rf_wd <= w_wr_dat;
      end
    end
  end

  assign rf_we_o = r_rf_we;
  assign rf_wa_o = r_rf_wa;
  assign rf_wd_o = r_rf_wd;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_thor2022_rf_scoreboard.sv
// Directed bench for thor2022_rf_scoreboard: literal expectations plus a cycle model compared every cycle.
module tb_thor2022_rf_scoreboard;

  localparam int STARVE_LIM = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        iss_v_i;
  logic [5:0]  iss_rt_i, iss_ra_i, iss_rb_i, iss_rc_i;
  logic        iss_rdy_o;
  logic        alu_wb_v_i;
  logic [5:0]  alu_wb_rt_i;
  logic [63:0] alu_wb_dat_i;
  logic        alu_wb_rdy_o;
  logic        mem_wb_v_i;
  logic [5:0]  mem_wb_rt_i;
  logic [63:0] mem_wb_dat_i;
  logic        mem_wb_rdy_o;
  logic        rf_we_o;
  logic [5:0]  rf_wa_o;
  logic [63:0] rf_wd_o;
  logic [63:0] busy_o;

  int n_checks = 0;
  int n_errors = 0;

  thor2022_rf_scoreboard #(.STARVE_LIM(STARVE_LIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .iss_v_i(iss_v_i), .iss_rt_i(iss_rt_i), .iss_ra_i(iss_ra_i),
    .iss_rb_i(iss_rb_i), .iss_rc_i(iss_rc_i), .iss_rdy_o(iss_rdy_o),
    .alu_wb_v_i(alu_wb_v_i), .alu_wb_rt_i(alu_wb_rt_i),
    .alu_wb_dat_i(alu_wb_dat_i), .alu_wb_rdy_o(alu_wb_rdy_o),
    .mem_wb_v_i(mem_wb_v_i), .mem_wb_rt_i(mem_wb_rt_i),
    .mem_wb_dat_i(mem_wb_dat_i), .mem_wb_rdy_o(mem_wb_rdy_o),
    .rf_we_o(rf_we_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o), .busy_o(busy_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- model ----------------
  typedef struct {
    logic [5:0]  rt;
    logic [63:0] dat;
  } wb_t;

  bit          m_valid = 1'b0;
  bit [63:0]   m_busy;
  wb_t         m_hold[$];
  int          m_lost;
  bit          m_we;
  logic [5:0]  m_wa;
  logic [63:0] m_wd;

  always @(negedge clk_i) begin
    bit [63:0] vis;
    bit        e_iss, e_alu, e_mem, starved, hold_goes, got;
    wb_t       w;
    vis = m_busy;
`ifdef THOR2022_SB_WBBYPASS_EN
    if (m_we) vis[m_wa] = 1'b0;
`endif
    e_iss     = !(vis[iss_ra_i] || vis[iss_rb_i] || vis[iss_rc_i] || vis[iss_rt_i]);
    starved   = (m_hold.size() > 0) && (m_lost >= STARVE_LIM);
    e_alu     = !starved;
    hold_goes = (m_hold.size() > 0) && (!alu_wb_v_i || starved);
    e_mem     = (m_hold.size() == 0) || hold_goes;

    if (m_valid) begin
      chk("cmp_iss_rdy", iss_rdy_o, e_iss);
      chk("cmp_alu_rdy", alu_wb_rdy_o, e_alu);
      chk("cmp_mem_rdy", mem_wb_rdy_o, e_mem);
      chk("cmp_busy", busy_o, m_busy);
      chk("cmp_rf_we", rf_we_o, m_we);
      if (m_we) begin
        chk("cmp_rf_wa", rf_wa_o, m_wa);
        chk("cmp_rf_wd", rf_wd_o, m_wd);
      end
    end

    if (!rst_ni) begin
      m_valid = 1'b1;
      m_busy  = '0;
      m_hold.delete();
      m_lost  = 0;
      m_we    = 1'b0;
      m_wa    = '0;
      m_wd    = '0;
    end else if (m_valid) begin
      if (m_we) m_busy[m_wa] = 1'b0;
      if (iss_v_i && e_iss && iss_rt_i != 0) m_busy[iss_rt_i] = 1'b1;
      if (flush_i) m_busy = '0;
      got = 1'b0;
      if (hold_goes) begin
        w = m_hold.pop_front();
        got = 1'b1;
      end else if (alu_wb_v_i && e_alu) begin
        w.rt = alu_wb_rt_i;
        w.dat = alu_wb_dat_i;
        got = 1'b1;
      end
      if (m_hold.size() > 0 && !hold_goes) m_lost = m_lost + 1;
      else m_lost = 0;
      if (got && hold_goes) m_lost = 0;
      m_we = got && (w.rt != 0);
      if (m_we) begin
        m_wa = w.rt;
        m_wd = w.dat;
      end
      if (mem_wb_v_i && e_mem) begin
        w.rt = mem_wb_rt_i;
        w.dat = mem_wb_dat_i;
        m_hold.push_back(w);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr();
    flush_i = 0; iss_v_i = 0; iss_rt_i = 0; iss_ra_i = 0; iss_rb_i = 0; iss_rc_i = 0;
    alu_wb_v_i = 0; alu_wb_rt_i = 0; alu_wb_dat_i = 0;
    mem_wb_v_i = 0; mem_wb_rt_i = 0; mem_wb_dat_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    clr();
    rst_ni = 0;
    tick(); tick();
    chk("reset_busy", busy_o, 64'd0);
    chk("reset_iss_rdy", iss_rdy_o, 1);
    chk("reset_rf_we", rf_we_o, 0);
    chk("reset_alu_rdy", alu_wb_rdy_o, 1);
    chk("reset_mem_rdy", mem_wb_rdy_o, 1);
    rst_ni = 1;

    // RAW hazard on r5 cleared by an ALU writeback
    tick();
    iss_v_i = 1; iss_rt_i = 6'd5; #1;
    chk("raw_first_issue_rdy", iss_rdy_o, 1);
    tick();
    iss_rt_i = 0; iss_ra_i = 6'd5; #1;
    chk("raw_busy5", busy_o, 64'h20);
    chk("raw_blocked", iss_rdy_o, 0);
    tick();
    alu_wb_v_i = 1; alu_wb_rt_i = 6'd5; alu_wb_dat_i = 64'h55; #1;
    chk("raw_blocked_wb_cycle", iss_rdy_o, 0);
    chk("raw_alu_rdy", alu_wb_rdy_o, 1);
    tick();
    alu_wb_v_i = 0; #1;
    chk("raw_rf_we", rf_we_o, 1);
    chk("raw_rf_wa", rf_wa_o, 6'd5);
    chk("raw_rf_wd", rf_wd_o, 64'h55);
`ifdef THOR2022_SB_WBBYPASS_EN
    chk("raw_rdy_n1", iss_rdy_o, 1);
`else
    chk("raw_rdy_n1", iss_rdy_o, 0);
`endif
    tick(); #1;
    chk("raw_rdy_n2", iss_rdy_o, 1);
    chk("raw_busy_clear", busy_o, 64'd0);

    // Set and clear of r44 on the same edge
    clr(); iss_v_i = 1; iss_rt_i = 6'd44;
    tick();
    clr(); alu_wb_v_i = 1; alu_wb_rt_i = 6'd44; alu_wb_dat_i = 64'h44;
    tick();
    clr(); iss_v_i = 1; iss_rt_i = 6'd44; #1;
`ifdef THOR2022_SB_WBBYPASS_EN
    chk("sp_same_edge_rdy", iss_rdy_o, 1);
    tick();
    chk("sp_set_wins", busy_o[44], 1);
`else
    chk("sp_same_edge_rdy", iss_rdy_o, 0);
    tick();
    chk("sp_cleared", busy_o[44], 0);
`endif
    tick();
    clr(); #1;
    chk("sp_busy44", busy_o, 64'd1 << 44);

    // Memory writeback starved by a continuous ALU stream
    alu_wb_v_i = 1; alu_wb_rt_i = 6'd10; alu_wb_dat_i = 64'h1000;
    mem_wb_v_i = 1; mem_wb_rt_i = 6'd7; mem_wb_dat_i = 64'hABCD; #1;
    chk("starve_mem_rdy", mem_wb_rdy_o, 1);
    for (int i = 1; i <= STARVE_LIM + 1; i++) begin
      tick();
      mem_wb_v_i = 0; alu_wb_rt_i = 6'(10 + i); alu_wb_dat_i = 64'h1000 + 64'(i); #1;
      chk("starve_alu_rdy", alu_wb_rdy_o, (i == STARVE_LIM + 1) ? 1'b0 : 1'b1);
      chk("starve_mem_busy", mem_wb_rdy_o, (i == STARVE_LIM + 1) ? 1'b1 : 1'b0);
    end
    tick(); #1;
    chk("starve_rf_we", rf_we_o, 1);
    chk("starve_rf_wa", rf_wa_o, 6'd7);
    chk("starve_rf_wd", rf_wd_o, 64'hABCD);
    tick();
    clr(); #1;
    chk("starve_alu_retry", rf_wa_o, 6'd14);

    // Hold drains while a new load arrives on the same cycle
    mem_wb_v_i = 1; mem_wb_rt_i = 6'd8; mem_wb_dat_i = 64'h1;
    tick();
    mem_wb_rt_i = 6'd9; mem_wb_dat_i = 64'h2; #1;
    chk("reload_mem_rdy", mem_wb_rdy_o, 1);
    tick();
    mem_wb_v_i = 0; #1;
    chk("reload_wa1", rf_wa_o, 6'd8);
    chk("reload_wd1", rf_wd_o, 64'h1);
    tick(); #1;
    chk("reload_wa2", rf_wa_o, 6'd9);
    chk("reload_wd2", rf_wd_o, 64'h2);

    // Writeback to r0 is swallowed
    tick();
    alu_wb_v_i = 1; alu_wb_rt_i = 6'd0; alu_wb_dat_i = 64'hFFFF; #1;
    chk("r0_alu_rdy", alu_wb_rdy_o, 1);
    tick();
    clr(); #1;
    chk("r0_no_we", rf_we_o, 0);
    chk("r0_busy", busy_o, 64'd1 << 44);

    // Flush with a pending hold write to r3
    iss_v_i = 1; iss_rt_i = 6'd3;
    tick();
    iss_rt_i = 6'd9;
    tick();
    clr(); #1;
    chk("flush_pre_busy", busy_o, (64'd1 << 44) | (64'd1 << 9) | (64'd1 << 3));
    alu_wb_v_i = 1; alu_wb_rt_i = 6'd20; alu_wb_dat_i = 64'h20;
    mem_wb_v_i = 1; mem_wb_rt_i = 6'd3; mem_wb_dat_i = 64'h33;
    tick();
    mem_wb_v_i = 0; flush_i = 1; iss_v_i = 1; iss_rt_i = 6'd12; #1;
    chk("flush_iss_rdy", iss_rdy_o, 1);
    tick();
    flush_i = 0; iss_v_i = 0; iss_rt_i = 0; #1;
    chk("flush_busy", busy_o, 64'd0);
    found = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (rf_we_o && rf_wa_o == 6'd3 && rf_wd_o == 64'h33) found = 1;
    end
    chk("flush_hold_write", found, 1);

    // Reset mid-operation drops the held load
    clr(); alu_wb_v_i = 1; alu_wb_rt_i = 6'd21; alu_wb_dat_i = 64'h21;
    mem_wb_v_i = 1; mem_wb_rt_i = 6'd22; mem_wb_dat_i = 64'h22;
    tick();
    mem_wb_v_i = 0; rst_ni = 0;
    tick();
    rst_ni = 1; clr(); #1;
    chk("midrst_mem_rdy", mem_wb_rdy_o, 1);
    chk("midrst_busy", busy_o, 64'd0);
    found = 0;
    for (int k = 0; k < 5; k++) begin
      if (rf_we_o) found = 1;
      tick();
    end
    chk("midrst_no_write", found, 0);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
